// File: rtl/led_status_ctrl_pkg.sv
// Purpose : shared types and timing helpers for the status-LED driver.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: led_mode_t per-channel display mode, helpers deriving blink
//           half-period and millisecond divider from the clock frequency.
package led_status_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_DIRECT  = 2'b00,
        LED_BLINK   = 2'b01,
        LED_STRETCH = 2'b10,
        LED_OFF     = 2'b11
    } led_mode_t;

    // Cycles per blink half-period.
    function automatic int calc_half(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

    // Cycles per millisecond tick.
    function automatic int calc_ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Purpose : bundle of game-side status/config inputs and the LED outputs.
// Latency : n/a (wires only).
// Backpr. : none; config writes are always accepted.
// Signals : status_in (raw status bits), cfg_wr/cfg_idx/cfg_mode (mode write),
//           led (registered LED drive). master = game logic, slave = LED driver.
interface led_status_ctrl_if #(
    parameter int NUM_LED = 4
);
    import led_status_ctrl_pkg::*;

    localparam int IDX_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    logic [NUM_LED-1:0] status_in;
    logic               cfg_wr;
    logic [IDX_W-1:0]   cfg_idx;
    led_mode_t          cfg_mode;
    logic [NUM_LED-1:0] led;

    modport master (
        output status_in, cfg_wr, cfg_idx, cfg_mode,
        input  led
    );

    modport slave (
        input  status_in, cfg_wr, cfg_idx, cfg_mode,
        output led
    );

endinterface

// File: rtl/led_status_ctrl_tick.sv
// Purpose : free-running millisecond tick and shared blink phase generator.
// Latency : ms_tick_o is decoded from the counter state (valid during the cycle
//           before the counter wraps); blink_phase_o is a register.
// Backpr. : none, free-running.
// Ports   : clk_i, rst_ni (async, active low), ms_tick_o, blink_phase_o.
module led_tick_gen
    import led_status_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 60_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic ms_tick_o,
    output logic blink_phase_o
);

    localparam int HALF   = calc_half(CLK_HZ, BLINK_HZ);
    localparam int MS_DIV = calc_ms_div(CLK_HZ);
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              half_wrap;
    logic              ms_wrap;

    always_comb begin
        half_wrap     = (half_cnt_q == HALF_W'(HALF - 1));
        ms_wrap       = (ms_cnt_q == MS_W'(MS_DIV - 1));
        half_cnt_d    = half_wrap ? '0 : half_cnt_q + HALF_W'(1);
        ms_cnt_d      = ms_wrap ? '0 : ms_cnt_q + MS_W'(1);
        blink_phase_d = half_wrap ? ~blink_phase_q : blink_phase_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_cnt_q    <= '0;
            ms_cnt_q      <= '0;
            blink_phase_q <= 1'b1;   // first blink on-phase starts straight out of reset
        end else begin
            half_cnt_q    <= half_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign ms_tick_o     = ms_wrap;
    assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Purpose : maps NUM_LED status bits onto LEDs with per-channel DIRECT/BLINK/STRETCH/OFF mode.
// Latency : 1 cycle status_in -> led; a mode write affects led from the second edge after the strobe.
// Backpr. : none; one config write per cycle, out-of-range indices ignored.
// Ports   : clk60MHz, rst_n (async, active low), bus (slave modport: status_in,
//           cfg_wr, cfg_idx, cfg_mode in; led out).
module led_status_ctrl
    import led_status_ctrl_pkg::*;
#(
    parameter int NUM_LED    = 4,
    parameter int CLK_HZ     = 60_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int STRETCH_MS = 100
) (
    input  logic              clk60MHz,
    input  logic              rst_n,
    led_status_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(STRETCH_MS + 1);

    logic               ms_tick;
    logic               blink_phase;
    logic               cfg_hit;
    logic [NUM_LED-1:0] status_q;
    logic [NUM_LED-1:0] led_q, led_d;

    led_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) u_tick (
        .clk_i         (clk60MHz),
        .rst_ni        (rst_n),
        .ms_tick_o     (ms_tick),
        .blink_phase_o (blink_phase)
    );

    // Indices beyond the channel count leave every channel untouched.
    assign cfg_hit = bus.cfg_wr && (int'(bus.cfg_idx) < NUM_LED);

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        led_mode_t        mode_q, mode_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             wr_sel;
        logic             rise;
        logic             ch_led_d;

        always_comb begin
            wr_sel = cfg_hit && (int'(bus.cfg_idx) == i);
            rise   = bus.status_in[i] & ~status_q[i];
            mode_d = wr_sel ? bus.cfg_mode : mode_q;

            // Priority: config clear, then reload on rise (beats a coincident tick), then decay.
            cnt_d = cnt_q;
            if (wr_sel) begin
                cnt_d = '0;
            end else if (rise) begin
                cnt_d = CNT_W'(STRETCH_MS);
            end else if (ms_tick && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end

            // Uses the mode currently held, so a write shows up one edge later.
            ch_led_d = 1'b0;
            unique case (mode_q)
                LED_DIRECT:  ch_led_d = bus.status_in[i];
                LED_BLINK:   ch_led_d = bus.status_in[i] & blink_phase;
                LED_STRETCH: ch_led_d = bus.status_in[i] | rise | (cnt_q != '0);
                LED_OFF:     ch_led_d = 1'b0;
                default:     ch_led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk60MHz or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= LED_DIRECT;
                cnt_q  <= '0;
            end else begin
                mode_q <= mode_d;
                cnt_q  <= cnt_d;
            end
        end

        assign led_d[i] = ch_led_d;
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            led_q    <= '0;
        end else begin
            status_q <= bus.status_in;
            led_q    <= led_d;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Purpose : self-checking bench for led_status_ctrl (NUM_LED=4, HALF=10, tick every 10 cycles, STRETCH_MS=3).
// Latency : expectations are keyed to the edge count since the last reset release.
// Backpr. : n/a.
module tb_led_status_ctrl;
    import led_status_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;

    typedef struct {
        int         at;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];

    led_status_ctrl_if #(.NUM_LED(4)) bus ();

    led_status_ctrl #(
        .NUM_LED    (4),
        .CLK_HZ     (10_000),
        .BLINK_HZ   (500),
        .STRETCH_MS (3)
    ) dut (
        .clk60MHz (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value k seen at a negedge means k posedges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: led=%b expected %b", name, act, exp);
    endtask

    task automatic expect_at(input int at, input logic [3:0] val, input string name);
        sb.push_back('{at, val, $sformatf("%s@%0d", name, at)});
    endtask

    // Monitor: compares the LED output against every expectation due this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                n_total++;
                $display("FAIL %s: not sampled (edge %0d) expected %b", e.name, cyc, e.val);
            end else begin
                check(e.name, bus.led, e.val);
            end
        end
    end

    task automatic restart();
        rst_n         = 1'b0;
        bus.status_in = 4'h0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_idx   = 2'd0;
        bus.cfg_mode  = LED_DIRECT;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic wr, input logic [1:0] idx, input led_mode_t m);
        bus.cfg_wr   = wr;
        bus.cfg_idx  = idx;
        bus.cfg_mode = m;
    endtask

    initial begin
        logic       b1;
        logic       b2;
        n_pass  = 0;
        n_total = 0;

        // Reset state, DIRECT default, async assertion mid-operation.
        rst_n         = 1'b0;
        bus.status_in = 4'h0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_idx   = 2'd0;
        bus.cfg_mode  = LED_DIRECT;
        repeat (3) @(negedge clk);
        check("reset_led", bus.led, 4'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.status_in = 4'hF;
            expect_at(k, 4'hF, "direct_F");
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check("async_reset", bus.led, 4'h0);
        bus.status_in = 4'b1010;
        @(negedge clk);
        check("held_in_reset", bus.led, 4'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_at(k, 4'b1010, "direct_1010");
            @(negedge clk);
        end

        // Blink on channel 0: on for edges 2..10, off 11..20, on 21..30, off 31..40.
        restart();
        for (int k = 1; k <= 60; k++) begin
            bus.status_in = (k <= 40) ? 4'b0001 : 4'b0000;
            cfg(k == 1, 2'd0, LED_BLINK);
            if (k == 1)       b1 = 1'b1;
            else if (k <= 40) b1 = (((k - 1) / 10) % 2) == 0;
            else              b1 = 1'b0;
            expect_at(k, {3'b000, b1}, "blink");
            @(negedge clk);
        end

        // Stretch: pulse at edge 3, ticks at edges 10/20/30 -> lit edges 3..30.
        restart();
        for (int k = 1; k <= 40; k++) begin
            bus.status_in = (k == 3) ? 4'b0100 : 4'b0000;
            cfg(k == 1, 2'd2, LED_STRETCH);
            expect_at(k, (k >= 3 && k <= 30) ? 4'b0100 : 4'b0000, "stretch");
            @(negedge clk);
        end

        // Retrigger: pulses at edges 3 and 18 -> reload, lit edges 3..40.
        restart();
        for (int k = 1; k <= 50; k++) begin
            bus.status_in = (k == 3 || k == 18) ? 4'b0100 : 4'b0000;
            cfg(k == 1, 2'd2, LED_STRETCH);
            expect_at(k, (k >= 3 && k <= 40) ? 4'b0100 : 4'b0000, "retrigger");
            @(negedge clk);
        end

        // Rise on the tick edge 10: reload wins, lit edges 10..40.
        restart();
        for (int k = 1; k <= 50; k++) begin
            bus.status_in = (k == 10) ? 4'b0100 : 4'b0000;
            cfg(k == 1, 2'd2, LED_STRETCH);
            expect_at(k, (k >= 10 && k <= 40) ? 4'b0100 : 4'b0000, "rise_on_tick");
            @(negedge clk);
        end

        // Config edges: ch1 OFF at edge 5 (dark from 6); ch2 stretch cleared by DIRECT at 8,
        // back to STRETCH at 12 stays dark.
        restart();
        for (int k = 1; k <= 20; k++) begin
            bus.status_in = (k == 3) ? 4'b0110 : 4'b0010;
            if (k == 1)       cfg(1'b1, 2'd2, LED_STRETCH);
            else if (k == 5)  cfg(1'b1, 2'd1, LED_OFF);
            else if (k == 8)  cfg(1'b1, 2'd2, LED_DIRECT);
            else if (k == 12) cfg(1'b1, 2'd2, LED_STRETCH);
            else              cfg(1'b0, 2'd0, LED_DIRECT);
            b1 = (k <= 5);
            b2 = (k >= 3 && k <= 8);
            expect_at(k, {1'b0, b2, b1, 1'b0}, "config");
            @(negedge clk);
        end
        cfg(1'b0, 2'd0, LED_DIRECT);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            n_total++;
            $display("FAIL %s: never compared expected %b", sb[0].name, sb[0].val);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
